pin_route_matrix: RTL and testbench
===================================

// Module: pin_route_matrix
// PURPOSE
//  Parametrised, runtime-configurable pin-to-pin router for the device pad ring.
//  N_CH channels each copy one input pin to one output pin, optionally inverted and optionally registered.
//  Configuration is written into a shadow table and committed atomically. Pin pads and tristate are outside this block.
// PARAMETERS
//  N_PINS       29  number of device pins (pin_in/pin_out/pin_oe width)
//  N_CH         4   number of routing channels
//  SYNC_STAGES  2   input synchroniser depth, >=1
//  PIN_W        $clog2(N_PINS)  derived, pin index width (localparam)
// PORTS
//  clk          in   1          single clock
//  rst          in   1          synchronous, active-high reset
//  pin_in       in   N_PINS     raw pin levels from pads
//  pin_out      out  N_PINS     routed output levels
//  pin_oe       out  N_PINS     1 = pin driven by a channel
//  cfg_valid    in   1          cfg write request
//  cfg_ready    out  1          block accepts cfg write/commit this cycle
//  cfg_addr     in   $clog2(N_CH)  channel index
//  cfg_data     in   2*PIN_W+3  {en, regd, inv, dst[PIN_W], src[PIN_W]}
//  cfg_commit   in   1          copy shadow table to active table
//  conflict     out  1          sticky: two enabled channels share a dst
//  cfg_err      out  1          sticky: src or dst >= N_PINS was committed
// BEHAVIOUR
//  Reset: shadow and active tables all-zero (all channels disabled); sync chain, channel regs, pin_out, pin_oe,
//   conflict and cfg_err = 0; cfg_ready = 1; FSM = IDLE.
//  Input sync: every pin_in bit passes SYNC_STAGES flops; s = sync output.
//  Channel c (active cfg en=1): v = s[src] ^ inv; regd=0 -> drive v; regd=1 -> drive flop of v (+1 cycle).
//  Outputs registered: pin_out[dst] <= drive, pin_oe[dst] <= 1. Undriven pins: pin_out = 0, pin_oe = 0.
//  Latency pin_in -> pin_out: SYNC_STAGES+1 cycles (regd=0), SYNC_STAGES+2 (regd=1).
//  Multiple enabled channels with same dst: lowest channel index wins; conflict set, held until rst.
//  Enabled channel with src or dst >= N_PINS: channel treated as disabled; cfg_err set, held until rst.
//  Config handshake: write occurs when cfg_valid && cfg_ready && !cfg_commit: shadow[cfg_addr] <= cfg_data.
//   cfg_addr >= N_CH: write ignored, cfg_err set.
//  FSM: IDLE --(cfg_commit && cfg_ready)--> COMMIT --(1 cycle)--> IDLE.
//   COMMIT: active <= shadow (all channels in the same edge), cfg_ready = 0.
//   The new mapping appears on pin_out one cycle after COMMIT.
//   cfg_commit together with cfg_valid in IDLE: commit wins; the write is not accepted (cfg_ready is high,
//    but the write does not take effect).
//   Shadow writes never affect outputs before a commit.
//  Channel regd flop: cleared by rst only. A channel enabled by commit outputs its stale/0 flop value for
//   the first cycle.
//  rst mid-COMMIT: reset wins; active table = 0, FSM = IDLE.
//  Commit with an unchanged shadow table is legal and produces no output glitch.
// STRUCTURE
//  router_pkg: chan_cfg_t struct {en, regd, inv, dst, src}; field width function of PIN_W; FSM state enum
//   {IDLE, COMMIT}.
//  Sub-module pin_route_channel: one per channel (generate loop). Takes s and its chan_cfg_t; outputs
//   drive, dst, valid (en && in-range).
//  Top level holds the sync chain, shadow/active tables, FSM, and priority merge to pin_out/pin_oe.
// TESTING
//  1 Legacy map: ch0 = {en=1, regd=0, inv=0, dst=2, src=1}, commit; toggle pin_in[1]
//     -> pin_out[2] follows after 3 cycles; pin_oe = 29'h4.
//  2 Invert + registered: ch1 = {1,1,1, dst=5, src=0}, commit; pin_in[0]=1
//     -> pin_out[5]=0 after 4 cycles.
//  3 Conflict: ch0 and ch2 both dst=7, src 3 and 4; commit; pin_in=29'h10
//     -> pin_out[7]=0 (ch0 wins); conflict=1 and stays 1 after reconfig.
//  4 Atomicity: write ch0 dst=9 without commit -> outputs unchanged 10 cycles;
//     commit -> cfg_ready=0 for exactly 1 cycle; pin_oe switches 29'h4 -> 29'h200.
//  5 Range error: ch3 = {1,0,0, dst=30, src=1}, commit -> cfg_err=1, pin_oe unaffected by ch3.
//  6 Reset mid-COMMIT: assert rst in COMMIT cycle -> next cycle pin_oe=0, pin_out=0, cfg_ready=1, flags=0.

Source files
------------

// File: rtl/pin_route_matrix_pkg.sv
// pin_route_matrix_pkg: shared channel config type, FSM states and range helper for the pin router
package pin_route_matrix_pkg;
  localparam int N_PINS_DEF = 29;
  localparam int PIN_W = $clog2(N_PINS_DEF);
  typedef struct packed {
    logic en;
    logic regd;
    logic inv;
    logic [PIN_W-1:0] dst;
    logic [PIN_W-1:0] src;
  } chan_cfg_t;
  typedef enum logic {IDLE, COMMIT} state_t;
  function automatic logic in_range(input logic [PIN_W-1:0] idx, input int n);
    return 32'(idx) < n;
  endfunction
endpackage

// File: rtl/pin_route_channel.sv
// pin_route_channel: one routing channel, selects a synced pin, optionally inverts and registers it
module pin_route_channel
  import pin_route_matrix_pkg::*;
#(
  parameter int N_PINS = N_PINS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_PINS-1:0] s,
  input  chan_cfg_t         cfg,
  output logic              drive,
  output logic [PIN_W-1:0]  dst,
  output logic              valid
);
  logic src_ok;
  logic v;
  logic v_q;
  assign src_ok = in_range(cfg.src, N_PINS);
  assign valid  = cfg.en && src_ok && in_range(cfg.dst, N_PINS);
  assign v      = (src_ok ? s[cfg.src] : 1'b0) ^ cfg.inv;
  assign drive  = cfg.regd ? v_q : v;
  assign dst    = cfg.dst;
  // optional extra pipeline stage, runs regardless of regd so it holds the last value
  always_ff @(posedge clk)
    v_q <= rst ? 1'b0 : v;
endmodule

// File: rtl/pin_route_matrix.sv
// pin_route_matrix: runtime-configurable pin-to-pin router with shadow/active tables and atomic commit
module pin_route_matrix
  import pin_route_matrix_pkg::*;
#(
  parameter int N_PINS      = N_PINS_DEF,
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PINS-1:0]       pin_in,
  output logic [N_PINS-1:0]       pin_out,
  output logic [N_PINS-1:0]       pin_oe,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [$clog2(N_CH)-1:0] cfg_addr,
  input  logic [2*PIN_W+2:0]      cfg_data,
  input  logic                    cfg_commit,
  output logic                    conflict,
  output logic                    cfg_err
);
  logic [N_PINS-1:0] sync_q [SYNC_STAGES];
  logic [N_PINS-1:0] s;
  chan_cfg_t         shadow [N_CH];
  chan_cfg_t         active [N_CH];
  state_t            state;
  logic [N_CH-1:0]   drive;
  logic [N_CH-1:0]   valid;
  logic [PIN_W-1:0]  dst [N_CH];
  logic [N_PINS-1:0] nxt_out;
  logic [N_PINS-1:0] nxt_oe;
  logic              conflict_now;
  logic              range_err_now;
  logic              wr_en;
  logic              addr_ok;
  assign s       = sync_q[SYNC_STAGES-1];
  assign wr_en   = cfg_valid && cfg_ready && !cfg_commit;
  assign addr_ok = 32'(cfg_addr) < N_CH;
  // input synchroniser chain
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pin_route_channel #(.N_PINS(N_PINS)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .s     (s),
      .cfg   (active[c]),
      .drive (drive[c]),
      .dst   (dst[c]),
      .valid (valid[c])
    );
  end
  // priority merge (walk high to low so the lowest channel lands last) plus error detection
  always_comb begin
    nxt_out       = '0;
    nxt_oe        = '0;
    conflict_now  = 1'b0;
    range_err_now = 1'b0;
    for (int c = N_CH - 1; c >= 0; c--)
      if (valid[c]) begin
        nxt_out[dst[c]] = drive[c];
        nxt_oe[dst[c]]  = 1'b1;
      end
    for (int i = 0; i < N_CH; i++)
      for (int j = i + 1; j < N_CH; j++)
        if (valid[i] && valid[j] && dst[i] == dst[j]) conflict_now = 1'b1;
    for (int c = 0; c < N_CH; c++)
      if (active[c].en && !valid[c]) range_err_now = 1'b1;
  end
  // registered pin outputs
  always_ff @(posedge clk) begin
    pin_out <= rst ? '0 : nxt_out;
    pin_oe  <= rst ? '0 : nxt_oe;
  end
  // config handshake, commit FSM and sticky flags
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      conflict  <= 1'b0;
      cfg_err   <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        shadow[c] <= '0;
        active[c] <= '0;
      end
    end else begin
      conflict <= conflict | conflict_now;
      cfg_err  <= cfg_err | range_err_now | (wr_en && !addr_ok);
      if (wr_en && addr_ok) shadow[cfg_addr] <= chan_cfg_t'(cfg_data);
      if (state == IDLE) begin
        if (cfg_commit && cfg_ready) begin
          state     <= COMMIT;
          cfg_ready <= 1'b0;
        end
      end else begin
        for (int c = 0; c < N_CH; c++) active[c] <= shadow[c];
        state     <= IDLE;
        cfg_ready <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pin_route_matrix.sv
// tb_pin_route_matrix: directed self-checking bench for pin_route_matrix
module tb_pin_route_matrix;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [28:0] pin_in = '0;
  logic [28:0] pin_out;
  logic [28:0] pin_oe;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_addr = '0;
  logic [12:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        conflict;
  logic        cfg_err;
  int          checks = 0;
  int          errors = 0;

  pin_route_matrix dut (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (pin_in),
    .pin_out    (pin_out),
    .pin_oe     (pin_oe),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .conflict   (conflict),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic en, input logic regd, input logic inv,
                                     input logic [4:0] d, input logic [4:0] sr);
    return {en, regd, inv, d, sr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [12:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    cyc(1);
    cfg_commit = 1'b0;
    cyc(2);
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_pin_out", 32'(pin_out), 32'h0);
    chk("rst_pin_oe", 32'(pin_oe), 32'h0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
    chk("rst_conflict", 32'(conflict), 32'h0);
    chk("rst_cfg_err", 32'(cfg_err), 32'h0);

    wr(2'd0, mk(1, 0, 0, 5'd2, 5'd1));
    commit();
    chk("t1_oe", 32'(pin_oe), 32'h4);
    chk("t1_out0", 32'(pin_out), 32'h0);
    pin_in[1] = 1'b1;
    cyc(2);
    chk("t1_rise_early", 32'(pin_out[2]), 32'h0);
    cyc(1);
    chk("t1_rise", 32'(pin_out[2]), 32'h1);
    pin_in[1] = 1'b0;
    cyc(2);
    chk("t1_fall_early", 32'(pin_out[2]), 32'h1);
    cyc(1);
    chk("t1_fall", 32'(pin_out[2]), 32'h0);

    wr(2'd1, mk(1, 1, 1, 5'd5, 5'd0));
    commit();
    chk("t2_stale", 32'(pin_out[5]), 32'h0);
    chk("t2_oe", 32'(pin_oe), 32'h24);
    cyc(1);
    chk("t2_inv_idle", 32'(pin_out[5]), 32'h1);
    pin_in[0] = 1'b1;
    cyc(3);
    chk("t2_early", 32'(pin_out[5]), 32'h1);
    cyc(1);
    chk("t2_regd", 32'(pin_out[5]), 32'h0);

    pin_in = 29'h10;
    cyc(3);
    wr(2'd0, mk(1, 0, 0, 5'd7, 5'd3));
    wr(2'd2, mk(1, 0, 0, 5'd7, 5'd4));
    commit();
    chk("t3_conflict", 32'(conflict), 32'h1);
    chk("t3_oe", 32'(pin_oe), 32'hA0);
    chk("t3_out", 32'(pin_out), 32'h20);
    wr(2'd0, mk(1, 0, 0, 5'd2, 5'd1));
    wr(2'd1, 13'h0);
    wr(2'd2, 13'h0);
    commit();
    chk("t3_oe_reconf", 32'(pin_oe), 32'h4);
    chk("t3_conflict_sticky", 32'(conflict), 32'h1);
    chk("t3_no_cfg_err", 32'(cfg_err), 32'h0);

    wr(2'd0, mk(1, 0, 0, 5'd9, 5'd1));
    for (int i = 0; i < 10; i++) begin
      chk("t4_shadow_hold", 32'(pin_oe), 32'h4);
      cyc(1);
    end
    cfg_commit = 1'b1;
    cyc(1);
    cfg_commit = 1'b0;
    chk("t4_ready_low", 32'(cfg_ready), 32'h0);
    cyc(1);
    chk("t4_ready_back", 32'(cfg_ready), 32'h1);
    chk("t4_oe_old", 32'(pin_oe), 32'h4);
    cyc(1);
    chk("t4_oe_new", 32'(pin_oe), 32'h200);

    wr(2'd3, mk(1, 0, 0, 5'd30, 5'd1));
    commit();
    chk("t5_cfg_err", 32'(cfg_err), 32'h1);
    chk("t5_oe", 32'(pin_oe), 32'h200);
    pin_in = 29'h2;
    cyc(3);
    chk("t5_route", 32'(pin_out), 32'h200);

    cfg_commit = 1'b1;
    cyc(1);
    cfg_commit = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_oe", 32'(pin_oe), 32'h0);
    chk("t6_out", 32'(pin_out), 32'h0);
    chk("t6_ready", 32'(cfg_ready), 32'h1);
    chk("t6_conflict", 32'(conflict), 32'h0);
    chk("t6_cfg_err", 32'(cfg_err), 32'h0);
    cyc(3);
    chk("t6_active_clear", 32'(pin_oe), 32'h0);

    cfg_valid  = 1'b1;
    cfg_commit = 1'b1;
    cfg_addr   = 2'd0;
    cfg_data   = mk(1, 0, 0, 5'd9, 5'd1);
    cyc(1);
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    cyc(2);
    chk("t7_commit_wins_oe", 32'(pin_oe), 32'h0);
    commit();
    chk("t7_write_dropped", 32'(pin_oe), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
